mem_resp_model: RTL

MEM_RESP_MODEL -- requirements
Module: mem_resp_model

---
 rtl/mem_resp_model.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_resp_model.sv
// mem_resp_model: fixed-latency single-outstanding memory responder with
// request aliasing, abort detection and a saturating write counter.
module mem_resp_model #(
   parameter int ADDR_BITS = 6,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [29:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        protocol_err,
   output logic [15:0] wr_count
);
   localparam int DEPTH = 1 << ADDR_BITS;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 is_wr_q, is_wr_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
   logic                 ready_q, ready_d, perr_q, perr_d;
   logic [15:0]          wr_cnt_q, wr_cnt_d;
   logic [31:0]          mem_q [DEPTH];
   logic [31:0]          mem_d [DEPTH];
   logic                 req_held;
   logic                 unused_addr;
   assign unused_addr = ^mem_addr[29:ADDR_BITS];
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      perr_d   = perr_q;
      wr_cnt_d = wr_cnt_q;
      mem_d    = mem_q;
      // only the line that defined the latched op must stay asserted
      req_held = is_wr_q ? mem_write : mem_read;
      case (state_q)
         IDLE: if (mem_read || mem_write) begin
            is_wr_d = mem_write;
            addr_d  = mem_addr[ADDR_BITS-1:0];
            wdata_d = mem_wdata;
            perr_d  = perr_q | (mem_read & mem_write);
            cnt_d   = 4'(LATENCY - 1);
            if (LATENCY == 1) begin
               state_d = RESP;
               ready_d = 1'b1;
               rdata_d = mem_write ? rdata_q : mem_q[mem_addr[ADDR_BITS-1:0]];
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: if (!req_held) begin
            state_d = IDLE;
            perr_d  = 1'b1;
         end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               ready_d = 1'b1;
               rdata_d = is_wr_q ? rdata_q : mem_q[addr_q];
            end
         end
         RESP: begin
            state_d = IDLE;
            if (is_wr_q) begin
               mem_d[addr_q] = wdata_q;
               wr_cnt_d      = wr_cnt_q + 16'(wr_cnt_q != 16'hFFFF);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_wr_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         perr_q   <= 1'b0;
         wr_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_wr_q  <= is_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         perr_q   <= perr_d;
         wr_cnt_q <= wr_cnt_d;
         mem_q    <= mem_d;
      end
   end
   assign mem_rdata    = rdata_q;
   assign mem_ready    = ready_q;
   assign protocol_err = perr_q;
   assign wr_count     = wr_cnt_q;
endmodule
